regbus_arbiter: RTL



---
 rtl/regbus_pkg.sv | 16 +
 rtl/regbus_rr_pick.sv | 45 ++++
 rtl/regbus_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/regbus_pkg.sv
// Shared constants and FSM state type for the register-bus arbiter.
package regbus_pkg;

  localparam int REGBUS_AW     = 16;
  localparam int REGBUS_DW     = 16;
  localparam int REGBUS_IBUS_W = 34;

  localparam logic [REGBUS_AW-1:0] REGBUS_PARK_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } regbus_state_e;

endpackage

// File: rtl/regbus_rr_pick.sv
// Combinational winner selection for the register-bus arbiter.
// REGBUS_ARB_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
module regbus_rr_pick #(
  parameter int NREQ = 2,
  parameter int GW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last_grant,
  output logic [GW-1:0]   grant,
  output logic            valid
);

`ifdef REGBUS_ARB_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant = GW'(i);
        valid = 1'b1;
      end
    end
  end
`else
  logic [GW-1:0] idx;

  // Scan starts one past the previous winner so the last winner is considered last.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = GW'((int'(last_grant) + i) % NREQ);
      if (!valid && req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regbus_arbiter.sv
// Arbitrates NREQ masters onto the 16-bit register bus; one transaction per 3+RD_WAIT cycles.
// Optional build macro REGBUS_ARB_PRIO_EN switches arbitration to fixed priority.
module regbus_arbiter
  import regbus_pkg::*;
#(
  parameter int                   NREQ      = 2,
  parameter logic [REGBUS_AW-1:0] PARK_ADDR = REGBUS_PARK_ADDR,
  parameter int                   RD_WAIT   = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [REGBUS_AW*NREQ-1:0] req_addr,
  input  logic [REGBUS_DW*NREQ-1:0] req_wrdata,
  output logic [NREQ-1:0]          ack,
  output logic [REGBUS_DW-1:0]     rddata,
  output logic                     bus_wr,
  output logic [REGBUS_AW-1:0]     bus_addr,
  output logic [REGBUS_DW-1:0]     bus_wrdata,
  input  logic [REGBUS_DW-1:0]     bus_rddata,
  output logic                     busy,
  output regbus_state_e            dbg_state
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  regbus_state_e        state_q, state_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [2:0]           wait_q, wait_d;
  logic                 xfer_wr_q, xfer_wr_d;
  logic [NREQ-1:0]      ack_q, ack_d;
  logic [REGBUS_DW-1:0] rddata_q, rddata_d;
  logic                 bus_wr_q, bus_wr_d;
  logic [REGBUS_AW-1:0] bus_addr_q, bus_addr_d;
  logic [REGBUS_DW-1:0] bus_wrdata_q, bus_wrdata_d;
  logic                 busy_q, busy_d;

  logic [GW-1:0]        pick_idx;
  logic                 pick_valid;

  regbus_rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (pick_idx),
    .valid      (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_d       = wait_q;
    xfer_wr_d    = xfer_wr_q;
    ack_d        = '0;
    rddata_d     = rddata_q;
    bus_wr_d     = 1'b0;
    bus_addr_d   = bus_addr_q;
    bus_wrdata_d = bus_wrdata_q;
    case (state_q)
      IDLE: begin
        bus_addr_d = PARK_ADDR;
        if (pick_valid) begin
          bus_addr_d   = req_addr[int'(pick_idx)*REGBUS_AW +: REGBUS_AW];
          bus_wrdata_d = req_wrdata[int'(pick_idx)*REGBUS_DW +: REGBUS_DW];
          bus_wr_d     = req_wr[pick_idx];
          xfer_wr_d    = req_wr[pick_idx];
          last_grant_d = pick_idx;
          wait_d       = 3'(RD_WAIT);
          state_d      = XFER;
        end
      end
      XFER: begin
        // bus_wr falls after the first XFER cycle so the register commits once.
        if (wait_q == 3'd0) begin
          if (!xfer_wr_q) rddata_d = bus_rddata;
          ack_d[last_grant_q] = 1'b1;
          state_d             = DONE;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      DONE: begin
        bus_addr_d = PARK_ADDR;
        state_d    = IDLE;
      end
      default: begin
        bus_addr_d = PARK_ADDR;
        state_d    = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NREQ - 1);
      wait_q       <= 3'd0;
      xfer_wr_q    <= 1'b0;
      ack_q        <= '0;
      rddata_q     <= '0;
      bus_wr_q     <= 1'b0;
      bus_addr_q   <= PARK_ADDR;
      bus_wrdata_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_q       <= wait_d;
      xfer_wr_q    <= xfer_wr_d;
      ack_q        <= ack_d;
      rddata_q     <= rddata_d;
      bus_wr_q     <= bus_wr_d;
      bus_addr_q   <= bus_addr_d;
      bus_wrdata_q <= bus_wrdata_d;
      busy_q       <= busy_d;
    end
  end

  assign ack        = ack_q;
  assign rddata     = rddata_q;
  assign bus_wr     = bus_wr_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wrdata = bus_wrdata_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule
